// File: rtl/md_pkg.sv
// Shared encodings and helpers for the sequential multiply/divide unit.
package md_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // Widest value the negate helper handles; callers zero-extend and truncate.
   localparam int unsigned NEG_MAX_W = 128;

   function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] x);
      return ~x + NEG_MAX_W'(1);
   endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module md_iter_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] mq_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] mq_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;

   always_comb begin
      sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {acc_i, mq_i[WIDTH-1]};
      if (is_div_i) begin
         // Remainder stays below the divisor, so the difference fits in WIDTH bits.
         if (shifted >= {1'b0, opnd_i}) begin
            acc_o = WIDTH'(shifted - {1'b0, opnd_i});
            mq_o  = {mq_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = shifted[WIDTH-1:0];
            mq_o  = {mq_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = sum[WIDTH:1];
         mq_o  = {sum[0], mq_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit owning HI/LO; one bit per clock on magnitudes,
// sign fix-up in a final cycle. WIDTH up to 64 (bounded by the negate helper).
module mult_div_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned WW    = 2 * WIDTH;

   function automatic logic [WW-1:0] neg_2w(input logic [WW-1:0] x);
      return WW'(twos_neg(NEG_MAX_W'(x)));
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return WIDTH'(neg_2w(WW'(x)));
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic             div_zero_q, div_zero_d;

   logic             op_signed, op_div, sign_a, sign_b;
   logic [WIDTH-1:0] mag_a, mag_b, step_acc, step_mq;
   logic [WW-1:0]    prod;

   assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign op_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign sign_a    = op_signed & a_i[WIDTH-1];
   assign sign_b    = op_signed & b_i[WIDTH-1];
   assign mag_a     = sign_a ? neg_w(a_i) : a_i;
   assign mag_b     = sign_b ? neg_w(b_i) : b_i;

   md_iter_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .is_div_i(is_div_q),
      .acc_i   (acc_q),
      .mq_i    (mq_q),
      .opnd_i  (opnd_q),
      .acc_o   (step_acc),
      .mq_o    (step_mq)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mq_d       = mq_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      prod       = {acc_q, mq_q};
      unique case (state_q)
         StIdle: begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
            if (start_i) begin
               is_div_d  = op_div;
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               acc_d     = '0;
               mq_d      = mag_a;
               opnd_d    = mag_b;
               cnt_d     = CNT_W'(WIDTH);
               if (op_div && (b_i == '0)) begin
                  div_zero_d = 1'b1;
                  state_d    = StDone;
               end else begin
                  div_zero_d = 1'b0;
                  state_d    = StRun;
               end
            end
         end
         StRun: begin
            acc_d = step_acc;
            mq_d  = step_mq;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StFix;
         end
         StFix: begin
            if (is_div_q) begin
               lo_d = neg_res_q ? neg_w(mq_q) : mq_q;
               hi_d = neg_rem_q ? neg_w(acc_q) : acc_q;
            end else begin
               prod = neg_res_q ? neg_2w({acc_q, mq_q}) : {acc_q, mq_q};
               hi_d = prod[WW-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         mq_q       <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mq_q       <= mq_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone);
   assign div_zero_o = done_o & div_zero_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit at WIDTH=32 and WIDTH=8, sharing clock, reset and operand buses.
module tb_mult_div_unit;

   logic        clk, rst_n;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic [1:0]  start, hi_we, lo_we;   // bit 0 drives the 32-bit unit, bit 1 the 8-bit unit
   logic        busy32, done32, dz32, busy8, done8, dz8;
   logic [31:0] hi32, lo32;
   logic [7:0]  hi8, lo8;
   int          n_cmp, n_fail;
   logic [31:0] ref_hi [2];
   logic [31:0] ref_lo [2];

   typedef struct {
      int          w;
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz;
   } vec_t;
   vec_t vecs [14];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .op_i(op), .a_i(a), .b_i(b),
      .hi_we_i(hi_we[0]), .lo_we_i(lo_we[0]), .wdata_i(wdata), .busy_o(busy32),
      .done_o(done32), .div_zero_o(dz32), .hi_o(hi32), .lo_o(lo32)
   );

   mult_div_unit #(.WIDTH(8)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .op_i(op), .a_i(a[7:0]), .b_i(b[7:0]),
      .hi_we_i(hi_we[1]), .lo_we_i(lo_we[1]), .wdata_i(wdata[7:0]), .busy_o(busy8),
      .done_o(done8), .div_zero_o(dz8), .hi_o(hi8), .lo_o(lo8)
   );

   function automatic int sel(input int w);
      return (w == 32) ? 0 : 1;
   endfunction
   function automatic logic [31:0] mask(input int w);
      return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction
   function automatic logic get_busy(input int w);
      return (w == 32) ? busy32 : busy8;
   endfunction
   function automatic logic get_done(input int w);
      return (w == 32) ? done32 : done8;
   endfunction
   function automatic logic get_dz(input int w);
      return (w == 32) ? dz32 : dz8;
   endfunction
   function automatic logic [31:0] get_hi(input int w);
      return (w == 32) ? hi32 : {24'h0, hi8};
   endfunction
   function automatic logic [31:0] get_lo(input int w);
      return (w == 32) ? lo32 : {24'h0, lo8};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on sign- or zero-extended operands.
   function automatic void model(input int w, input logic [1:0] o, input logic [31:0] av, bv,
                                 input logic [31:0] ohi, olo,
                                 output logic [31:0] eh, el, output logic edz);
      logic [31:0] m, am, bm;
      longint      sa, sb, p, q, r;
      m  = mask(w);
      am = av & m;
      bm = bv & m;
      sa = longint'(am);
      sb = longint'(bm);
      if (!o[0] && am[w-1]) sa = sa - (longint'(1) << w);
      if (!o[0] && bm[w-1]) sb = sb - (longint'(1) << w);
      eh  = ohi;
      el  = olo;
      edz = 1'b0;
      if (!o[1]) begin
         p  = sa * sb;
         el = 32'(p) & m;
         eh = 32'(p >> w) & m;
      end else if (sb == 0) begin
         edz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         el = 32'(q) & m;
         eh = 32'(r) & m;
      end
   endfunction

   task automatic issue(input int w, input logic [1:0] o, input logic [31:0] av, bv);
      op = o;
      a  = av;
      b  = bv;
      start[sel(w)] = 1'b1;
      @(posedge clk); #1;
      start = '0;
      hi_we = '0;
      lo_we = '0;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
   endtask

   task automatic finish_op(input int w, input int elapsed, input logic [31:0] eh, el,
                            input logic edz, input string nm);
      int k;
      k = elapsed;
      while (get_done(w) !== 1'b1 && k < w + 10) begin
         @(posedge clk); #1;
         k++;
      end
      check({nm, " latency"}, k, edz ? 0 : w + 1);
      check({nm, " busy@done"}, get_busy(w), 1);
      check({nm, " hi"}, get_hi(w), eh & mask(w));
      check({nm, " lo"}, get_lo(w), el & mask(w));
      check({nm, " div_zero"}, get_dz(w), edz);
      @(posedge clk); #1;
      check({nm, " done pulse"}, get_done(w), 0);
      check({nm, " busy after"}, get_busy(w), 0);
      ref_hi[sel(w)] = eh & mask(w);
      ref_lo[sel(w)] = el & mask(w);
   endtask

   task automatic model_op(input int w, input logic [1:0] o, input logic [31:0] av, bv,
                           input string nm);
      logic [31:0] eh, el;
      logic        edz;
      model(w, o, av, bv, ref_hi[sel(w)], ref_lo[sel(w)], eh, el, edz);
      issue(w, o, av, bv);
      finish_op(w, 0, eh, el, edz, nm);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w, s, cnt;
      logic [31:0] av, bv, wd;
      logic [1:0]  o;
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      start = '0;
      hi_we = '0;
      lo_we = '0;
      op = '0;
      a = '0;
      b = '0;
      wdata = '0;
      ref_hi[0] = '0; ref_hi[1] = '0; ref_lo[0] = '0; ref_lo[1] = '0;

      vecs[0]  = '{32, 2'b00, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{32, 2'b01, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{32, 2'b00, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[3]  = '{32, 2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{32, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
      vecs[5]  = '{32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
      vecs[6]  = '{32, 2'b11, 32'h100,       32'h0,         32'h0,         32'h8000_0000, 1'b1};
      vecs[7]  = '{8,  2'b00, 32'hFD,        32'h07,        32'hFF,        32'hEB,        1'b0};
      vecs[8]  = '{8,  2'b01, 32'hFF,        32'h02,        32'h01,        32'hFE,        1'b0};
      vecs[9]  = '{8,  2'b00, 32'hFF,        32'h02,        32'hFF,        32'hFE,        1'b0};
      vecs[10] = '{8,  2'b10, 32'hF9,        32'h02,        32'hFF,        32'hFD,        1'b0};
      vecs[11] = '{8,  2'b00, 32'h80,        32'h80,        32'h40,        32'h00,        1'b0};
      vecs[12] = '{8,  2'b10, 32'h80,        32'hFF,        32'h00,        32'h80,        1'b0};
      vecs[13] = '{8,  2'b11, 32'h64,        32'h00,        32'h00,        32'h80,        1'b1};

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? 32 : 8;
         check($sformatf("reset busy w%0d", w), get_busy(w), 0);
         check($sformatf("reset done w%0d", w), get_done(w), 0);
         check($sformatf("reset dz w%0d", w), get_dz(w), 0);
         check($sformatf("reset hi w%0d", w), get_hi(w), 0);
         check($sformatf("reset lo w%0d", w), get_lo(w), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b);
         finish_op(vecs[i].w, 0, vecs[i].hi, vecs[i].lo, vecs[i].dz, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? 32 : 8;
         s = sel(w);

         // Second start during RUN must be dropped.
         issue(w, 2'b01, 32'd5, 32'd6);
         repeat (3) begin @(posedge clk); #1; end
         op = 2'b11; a = 32'd100; b = 32'd0; start[s] = 1'b1;
         @(posedge clk); #1;
         start = '0;
         finish_op(w, 4, 32'd0, 32'd30, 1'b0, $sformatf("restart w%0d", w));
         cnt = 0;
         repeat (4) begin @(posedge clk); #1; if (get_done(w)) cnt++; end
         check($sformatf("restart extra done w%0d", w), cnt, 0);

         // mthi/mtlo while busy are ignored.
         issue(w, 2'b00, 32'd3, 32'd4);
         @(posedge clk); #1;
         hi_we[s] = 1'b1; lo_we[s] = 1'b1; wdata = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         hi_we = '0; lo_we = '0;
         check($sformatf("busy lo_we w%0d", w), get_lo(w), ref_lo[s]);
         check($sformatf("busy hi_we w%0d", w), get_hi(w), ref_hi[s]);
         finish_op(w, 2, 32'd0, 32'd12, 1'b0, $sformatf("mult3x4 w%0d", w));

         // Idle writes land at the next edge.
         lo_we[s] = 1'b1; wdata = 32'h1234_5678;
         @(posedge clk); #1;
         lo_we = '0;
         check($sformatf("idle lo_we w%0d", w), get_lo(w), 32'h1234_5678 & mask(w));
         check($sformatf("idle lo_we hi kept w%0d", w), get_hi(w), ref_hi[s]);
         ref_lo[s] = 32'h1234_5678 & mask(w);
         hi_we[s] = 1'b1; wdata = 32'h0F0F_0F0F;
         @(posedge clk); #1;
         hi_we = '0;
         check($sformatf("idle hi_we w%0d", w), get_hi(w), 32'h0F0F_0F0F & mask(w));
         ref_hi[s] = 32'h0F0F_0F0F & mask(w);

         // Write on the accepting edge: kept by a div-by-zero, overwritten by a result.
         hi_we[s] = 1'b1; lo_we[s] = 1'b1; wdata = 32'h0000_AAAA;
         issue(w, 2'b11, 32'd100, 32'd0);
         finish_op(w, 0, 32'h0000_AAAA, 32'h0000_AAAA, 1'b1, $sformatf("wr+divz w%0d", w));
         lo_we[s] = 1'b1; wdata = 32'h5555_5555;
         issue(w, 2'b01, 32'd2, 32'd3);
         finish_op(w, 0, 32'd0, 32'd6, 1'b0, $sformatf("wr+mult w%0d", w));

         // Asynchronous reset in the middle of RUN.
         issue(w, 2'b00, 32'h1234, 32'h5678);
         repeat (9) begin @(posedge clk); #1; end
         check($sformatf("pre-reset busy w%0d", w), get_busy(w), 1);
         rst_n = 1'b0;
         #1;
         check($sformatf("abort busy w%0d", w), get_busy(w), 0);
         check($sformatf("abort done w%0d", w), get_done(w), 0);
         check($sformatf("abort hi w%0d", w), get_hi(w), 0);
         check($sformatf("abort lo w%0d", w), get_lo(w), 0);
         @(posedge clk); #1;
         rst_n = 1'b1;
         cnt = 0;
         repeat (w + 5) begin @(posedge clk); #1; if (get_done(w) || get_busy(w)) cnt++; end
         check($sformatf("abort no done w%0d", w), cnt, 0);
         ref_hi[0] = '0; ref_hi[1] = '0; ref_lo[0] = '0; ref_lo[1] = '0;
      end

      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? 32 : 8;
         s = sel(w);
         for (int n = 0; n < 120; n++) begin
            o  = 2'($urandom);
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
               0: bv = 32'd0;
               1: begin av = (w == 32) ? 32'h8000_0000 : 32'h80; bv = 32'hFFFF_FFFF; end
               2: bv = $urandom_range(0, 3);
               3: begin
                  wd = $urandom;
                  lo_we[s] = 1'b1; wdata = wd;
                  @(posedge clk); #1;
                  lo_we = '0;
                  ref_lo[s] = wd & mask(w);
                  check($sformatf("rand mtlo w%0d #%0d", w, n), get_lo(w), ref_lo[s]);
               end
               default: ;
            endcase
            model_op(w, o, av, bv, $sformatf("rand w%0d #%0d op%0d", w, n, o));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised sequential multiply/divide unit owning the HI/LO architectural registers of the multicycle core.
- Accepts one operation per start pulse and iterates one bit per clock: shift-add multiply, restoring divide.
- Signals completion with busy/done; the CPU control unit stalls on busy and reads hi/lo into the write-back mux.
- Successor to the fixed-width combinational HI/LO path: adds width generalisation, signed/unsigned modes, divide-by-zero flag and mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand width and width of each of hi and lo; legal range >= 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 mult signed, 01 multu, 10 div signed, 11 divu.
- a  in  WIDTH  multiplicand or dividend; sampled with start.
- b  in  WIDTH  multiplier or divisor; sampled with start.
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  high from accepting edge until return to IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  valid only with done; 1 means divisor was 0.
- hi  out  WIDTH  mult: upper product; div: remainder.
- lo  out  WIDTH  mult: lower product; div: quotient.

Behaviour:
- Reset (asserted, async): state IDLE; hi, lo, counter and internals 0; busy=0, done=0, div_zero=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 at edge N:
  - Latch |a|, |b| (magnitudes for signed ops; raw values for unsigned) and the result signs.
  - Set counter = WIDTH; next state RUN; busy=1.
- IDLE, div op with b==0: go directly to DONE with div_zero=1; hi/lo unchanged.
- RUN: one iteration per edge; counter decrements; after the WIDTH-th iteration (edge N+WIDTH) go to FIX.
- FIX (edge N+WIDTH+1):
  - Apply two's-complement sign correction.
  - mult: product negative iff signs differ; {hi,lo} receives the full 2*WIDTH product.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Write hi/lo; next state DONE.
- DONE: done=1 for exactly one cycle; busy still 1; next edge returns to IDLE, where busy=0.
- Latency: done is observable in the cycle after edge N+WIDTH+1 (divide-by-zero case: the cycle after edge N).
- Signed div, MIN / -1: lo = MIN (wraps), hi = 0, div_zero = 0.
- start while busy: ignored entirely, with no queuing.
- hi_we/lo_we:
  - Honoured only when busy=0; the write lands at that edge.
  - Ignored while busy.
  - Same edge as an accepted start: the write still occurs; the later operation result overwrites it.
- hi/lo hold their value except on an FIX write, an mthi/mtlo write, or reset.
- op, a, b changing mid-operation: no effect; only latched copies are used.
- Reset mid-operation: immediate abort to the reset state; no done pulse.

Decomposition:
- Shared package md_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding enum.
  - helper function for two's-complement negate.
- One natural sub-module, md_iter_step: combinational single iteration.
  - Multiply: conditional add plus right shift of the {acc, multiplier} pair.
  - Divide: trial subtract plus left shift of the {rem, quotient} pair.
  - The top module holds the FSM, counter and registers.

Test Plan (WIDTH=32):
- mult a=-3 (FFFFFFFD), b=7 -> done exactly 34 cycles after the start edge; hi=FFFFFFFF, lo=FFFFFFEB; busy low the following cycle.
- multu a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE; mult signed, same operands -> hi=FFFFFFFF, lo=FFFFFFFE.
- div a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- divu a=100, b=0 -> done one cycle after the start edge, div_zero=1, hi/lo retain their prior values.
- Protocol checks:
  - Second start pulse while busy -> ignored; only one done pulse.
  - lo_we while busy -> lo unchanged.
  - lo_we in IDLE with wdata=12345678 -> lo=12345678 next cycle.
  - reset deasserted->asserted at RUN cycle 10 -> busy=0, hi=lo=0, no done pulse.
- Rerun all directed cases with WIDTH=8, for example mult 0x80*0x80 signed -> hi=0x40, lo=0x00.
